alu_8bit_seq: RTL and testbench

Sequential, handshaked 8-bit ALU execution unit: the responder side of the ALU command interface. It accepts one operation per `start` pulse, latches operands, executes over one or more clock cycles, registers `Y` and flags, and signals completion with a one-cycle `done` pulse. It sits between a command sequencer (or testbench driver) and the datapath. It shares the combinational ALU's opcode map and flag semantics, and adds multi-bit iterative shifts by `B[2:0]`.

---
 rtl/alu_8bit_seq.sv | 213 +++++++++++++++++++++
 tb/tb_alu_8bit_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_8bit_seq.sv
// alu_8bit_seq: sequential, handshaked 8-bit ALU execution unit.
//
// Accepts one command per start strobe (when not busy), latches A, B and sel,
// executes over one or more cycles and registers Y plus flags. Completion is
// signalled by a one-cycle done pulse; results hold until the next done.
// Shifts (and rotates) iterate one bit per cycle, by B[2:0] positions.
//
// Optional feature macro: ALU_SEQ_ROTATE_EN
//   defined   -> opcode 1000 = ROL, 1001 = ROR (iterated like shifts)
//   undefined -> 1000 / 1001 are illegal opcodes
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      command strobe, honoured in IDLE and DONE
//   A, B       operands (B[2:0] = shift amount for shift/rotate ops)
//   sel        4-bit opcode
//   busy       high in EXEC and SHIFT
//   done       one-cycle completion pulse
//   Y          registered result
//   carry_out  registered carry / borrow / last bit shifted out
//   zero       registered (Y == 0)
//   overflow   registered signed overflow
//   illegal    registered unsupported-opcode flag
module alu_8bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
`ifdef ALU_SEQ_ROTATE_EN
  localparam logic [3:0] OP_ROL = 4'b1000;
  localparam logic [3:0] OP_ROR = 4'b1001;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, work_reg;
  logic [3:0]       sel_reg;
  logic [2:0]       cnt_reg;

  logic             accept;
  logic             shift_op;
  logic [2:0]       shift_n;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c, alu_o, alu_ill;
  logic [WIDTH-1:0] step_y;
  logic             step_c;
  logic [WIDTH:0]   sum_ext, diff_ext;

  // A new command is taken in IDLE, and also in DONE for back-to-back issue.
  assign accept  = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign shift_n = b_reg[2:0];

`ifdef ALU_SEQ_ROTATE_EN
  assign shift_op = (sel_reg == OP_SHL) || (sel_reg == OP_SHR) ||
                    (sel_reg == OP_ROL) || (sel_reg == OP_ROR);
`else
  assign shift_op = (sel_reg == OP_SHL) || (sel_reg == OP_SHR);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = EXEC;
      EXEC:    state_next = (shift_op && (shift_n != 3'd0)) ? SHIFT : DONE;
      SHIFT:   if (cnt_reg == 3'd1) state_next = DONE;
      DONE:    state_next = start ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_reg == EXEC) || (state_reg == SHIFT);
    done = (state_reg == DONE);
  end

  // Single-cycle result for non-shift ops and zero-length shifts.
  assign sum_ext  = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff_ext = {1'b0, a_reg} - {1'b0, b_reg};

  always_comb begin
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    alu_ill = 1'b0;
    case (sel_reg)
      OP_ADD: begin
        alu_y = sum_ext[WIDTH-1:0];
        alu_c = sum_ext[WIDTH];
        alu_o = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                (sum_ext[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y = diff_ext[WIDTH-1:0];
        alu_c = diff_ext[WIDTH];  // borrow out of the zero-extended subtract
        alu_o = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                (diff_ext[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_AND: alu_y = a_reg & b_reg;
      OP_OR:  alu_y = a_reg | b_reg;
      OP_XOR: alu_y = a_reg ^ b_reg;
      OP_NOT: alu_y = ~a_reg;
      OP_SHL, OP_SHR: alu_y = a_reg;  // only reached with n = 0
`ifdef ALU_SEQ_ROTATE_EN
      OP_ROL, OP_ROR: alu_y = a_reg;  // only reached with n = 0
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // One-bit step of the iterative shifter/rotator.
  always_comb begin
    step_y = {work_reg[WIDTH-2:0], 1'b0};
    step_c = work_reg[WIDTH-1];
    case (sel_reg)
      OP_SHR: begin
        step_y = {1'b0, work_reg[WIDTH-1:1]};
        step_c = work_reg[0];
      end
`ifdef ALU_SEQ_ROTATE_EN
      OP_ROL: begin
        step_y = {work_reg[WIDTH-2:0], work_reg[WIDTH-1]};
        step_c = work_reg[WIDTH-1];
      end
      OP_ROR: begin
        step_y = {work_reg[0], work_reg[WIDTH-1:1]};
        step_c = work_reg[0];
      end
`endif
      default: ;
    endcase
  end

  // Datapath: operand latches, shift working registers and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sel_reg   <= '0;
      work_reg  <= '0;
      cnt_reg   <= '0;
      Y         <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (accept) begin
        a_reg   <= A;
        b_reg   <= B;
        sel_reg <= sel;
      end
      case (state_reg)
        EXEC: begin
          if (shift_op && (shift_n != 3'd0)) begin
            work_reg <= a_reg;
            cnt_reg  <= shift_n;
          end else begin
            Y         <= alu_y;
            carry_out <= alu_c;
            zero      <= (alu_y == '0);
            overflow  <= alu_o;
            illegal   <= alu_ill;
          end
        end
        SHIFT: begin
          work_reg <= step_y;
          cnt_reg  <= cnt_reg - 3'd1;
          // Final step: the bit leaving now is the last one shifted out.
          if (cnt_reg == 3'd1) begin
            Y         <= step_y;
            carry_out <= step_c;
            zero      <= (step_y == '0);
            overflow  <= 1'b0;
            illegal   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_8bit_seq.sv
// Scoreboard testbench for alu_8bit_seq: the driver pushes hand-computed
// expected results (value, flags, latency in cycles) into a queue; a monitor
// pops and compares on every done pulse.
module tb_alu_8bit_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] A, B;
  logic [3:0] sel;
  logic       busy, done;
  logic [7:0] Y;
  logic       carry_out, zero, overflow, illegal;

  alu_8bit_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .sel(sel),
    .busy(busy), .done(done), .Y(Y), .carry_out(carry_out), .zero(zero),
    .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] y;
    logic       c, z, o, il;
    int         lat;
    int         issue;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.name, "_result{Y,c,z,o,ill}"},
              {20'd0, Y, carry_out, zero, overflow, illegal},
              {20'd0, mon_e.y, mon_e.c, mon_e.z, mon_e.o, mon_e.il});
        check({mon_e.name, "_latency"}, cyc - mon_e.issue, mon_e.lat);
      end
    end
  end

  // Issue one command at the current negedge; returns one cycle later with
  // operands scrambled so late operand changes are exercised.
  task automatic issue(input string name, input logic [3:0] s, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] y, input logic c,
                       input logic z, input logic o, input logic il, input int lat,
                       input bit push);
    exp_t e;
    A = a; B = b; sel = s; start = 1'b1;
    if (push) begin
      e.name = name; e.y = y; e.c = c; e.z = z; e.o = o; e.il = il;
      e.lat = lat; e.issue = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    A = 8'h5A; B = 8'hC3; sel = 4'b0001;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (q.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL wait_done_timeout: got done=%b, expected 1", done);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = 8'h00; B = 8'h00; sel = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, Y, carry_out, zero, overflow, illegal}, 14'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD with busy profile: busy for exactly one cycle, then done.
    issue("add_12_34", 4'b0000, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0, 2, 1);
    check("add_busy_exec", {busy, done}, 2'b10);
    @(negedge clk);
    check("add_busy_done", {busy, done}, 2'b01);
    drain(20);

    issue("add_80_80", 4'b0000, 8'h80, 8'h80, 8'h00, 1, 1, 1, 0, 2, 1); drain(20);
    issue("sub_11_55", 4'b0001, 8'h11, 8'h55, 8'hBC, 1, 0, 0, 0, 2, 1); drain(20);
    issue("sub_80_01", 4'b0001, 8'h80, 8'h01, 8'h7F, 0, 0, 1, 0, 2, 1); drain(20);

    // SHL by 7 with a start pulse mid-shift that must be ignored.
    issue("shl_03_7", 4'b0110, 8'h03, 8'h07, 8'h80, 1, 0, 0, 0, 9, 1);
    repeat (2) @(negedge clk);
    A = 8'h01; B = 8'h01; sel = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(20);
    repeat (4) @(negedge clk);
    check("shl_single_done_pending", q.size(), 0);

    issue("shr_80_0", 4'b0111, 8'h80, 8'h00, 8'h80, 0, 0, 0, 0, 2, 1); drain(20);
    issue("shr_81_1", 4'b0111, 8'h81, 8'h01, 8'h40, 1, 0, 0, 0, 3, 1); drain(20);
    issue("shl_01_3", 4'b0110, 8'h01, 8'h03, 8'h08, 0, 0, 0, 0, 5, 1); drain(20);
    issue("not_0f",   4'b0101, 8'h0F, 8'h33, 8'hF0, 0, 0, 0, 0, 2, 1); drain(20);
    issue("xor_aa_ff",4'b0100, 8'hAA, 8'hFF, 8'h55, 0, 0, 0, 0, 2, 1); drain(20);
    issue("and_f0_3c",4'b0010, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 2, 1); drain(20);
    issue("or_00_00", 4'b0011, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 2, 1); drain(20);
    issue("illegal_a",4'b1010, 8'h12, 8'h34, 8'h00, 0, 1, 0, 1, 2, 1); drain(20);
`ifdef ALU_SEQ_ROTATE_EN
    issue("rol_81_1", 4'b1000, 8'h81, 8'h01, 8'h03, 1, 0, 0, 0, 3, 1); drain(20);
    issue("ror_01_2", 4'b1001, 8'h01, 8'h02, 8'h40, 0, 0, 0, 0, 4, 1); drain(20);
`else
    issue("rol_81_1", 4'b1000, 8'h81, 8'h01, 8'h00, 0, 1, 0, 1, 2, 1); drain(20);
    issue("ror_01_2", 4'b1001, 8'h01, 8'h02, 8'h00, 0, 1, 0, 1, 2, 1); drain(20);
`endif

    // Put a non-zero result in Y, then abort a shift with reset.
    issue("add_40_01", 4'b0000, 8'h40, 8'h01, 8'h41, 0, 0, 0, 0, 2, 1); drain(20);
    issue("shl_ff_6_abort", 4'b0110, 8'hFF, 8'h06, 8'h00, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_outputs", {busy, done, Y, carry_out, zero, overflow, illegal}, 14'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_outputs_after", {busy, done, Y, carry_out, zero, overflow, illegal}, 14'd0);

    // Back-to-back: second start issued in the DONE cycle of the first.
    issue("b2b_add_01_02", 4'b0000, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0, 2, 1);
    wait_done(20);
    issue("b2b_sub_05_07", 4'b0001, 8'h05, 8'h07, 8'hFE, 1, 0, 0, 0, 2, 1);
    drain(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
